// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles SYNC/CMD/LEN/payload/CHK frames from UART receiver bytes.
// Ports: i_Clock, i_Rst_L (async active-low); i_RX_DV/i_RX_Byte byte strobe in;
//   o_Cmd_DV/o_Cmd/o_Len/o_Payload accepted frame; o_Err_DV/o_Err_Code rejected frame
//   (01 checksum, 10 length, 11 timeout); o_Busy while a frame is in progress.
// Optional: define UART_CMD_TIMEOUT_EN to abort frames idle for TIMEOUT_CLKS clocks.
`ifndef CLKS_PER_BIT
`define CLKS_PER_BIT 87
`endif
module uart_cmd_parser #(
  parameter int MAX_LEN = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT_CLKS = 10*`CLKS_PER_BIT*4
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_RX_DV,
  input  logic [7:0]           i_RX_Byte,
  output logic                 o_Cmd_DV,
  output logic [7:0]           o_Cmd,
  output logic [7:0]           o_Len,
  output logic [MAX_LEN*8-1:0] o_Payload,
  output logic                 o_Err_DV,
  output logic [1:0]           o_Err_Code,
  output logic                 o_Busy
);
  typedef enum logic [2:0] {IDLE, CMD, LEN, PAYLOAD, CHK} state_t;
  localparam logic [7:0] MAXL = 8'(MAX_LEN);
  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 2) begin : g_bad_param
    $error("uart_cmd_parser: parameter out of range");
  end
  state_t state;
  logic [7:0] cmd_w, len_w, acc, idx;
  logic [MAX_LEN*8-1:0] buf_w;
`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS);
  logic [TW-1:0] tmo;
`endif
  assign o_Busy = state != IDLE;
  always_ff @(posedge i_Clock or negedge i_Rst_L)
    if (!i_Rst_L) begin
      state <= IDLE;
      cmd_w <= '0;
      len_w <= '0;
      acc <= '0;
      idx <= '0;
      buf_w <= '0;
      o_Cmd_DV <= 1'b0;
      o_Cmd <= '0;
      o_Len <= '0;
      o_Payload <= '0;
      o_Err_DV <= 1'b0;
      o_Err_Code <= '0;
`ifdef UART_CMD_TIMEOUT_EN
      tmo <= '0;
`endif
    end else begin
      o_Cmd_DV <= 1'b0;
      o_Err_DV <= 1'b0;
      if (i_RX_DV)
        case (state)
          IDLE: if (i_RX_Byte == SYNC_BYTE) begin
            state <= CMD;
            acc <= '0;
            idx <= '0;
            buf_w <= '0;
          end
          CMD: begin
            cmd_w <= i_RX_Byte;
            acc <= i_RX_Byte;
            state <= LEN;
          end
          LEN: begin
            acc <= acc ^ i_RX_Byte;
            len_w <= i_RX_Byte;
            idx <= '0;
            if (i_RX_Byte > MAXL) begin
              o_Err_DV <= 1'b1;
              o_Err_Code <= 2'b10;
              state <= IDLE;
            end else
              state <= i_RX_Byte == 8'd0 ? CHK : PAYLOAD;
          end
          PAYLOAD: begin
            buf_w[{idx, 3'b000} +: 8] <= i_RX_Byte;
            acc <= acc ^ i_RX_Byte;
            idx <= idx + 8'd1;
            if (idx + 8'd1 == len_w) state <= CHK;
          end
          default: begin
            if (i_RX_Byte == acc) begin
              o_Cmd <= cmd_w;
              o_Len <= len_w;
              o_Payload <= buf_w;
              o_Cmd_DV <= 1'b1;
            end else begin
              o_Err_DV <= 1'b1;
              o_Err_Code <= 2'b01;
            end
            state <= IDLE;
          end
        endcase
`ifdef UART_CMD_TIMEOUT_EN
      // A byte in the expiry cycle wins: only idle cycles can abort the frame.
      if (i_RX_DV || state == IDLE)
        tmo <= '0;
      else if (tmo == TW'(TIMEOUT_CLKS - 1)) begin
        tmo <= '0;
        o_Err_DV <= 1'b1;
        o_Err_Code <= 2'b11;
        state <= IDLE;
      end else
        tmo <= tmo + 1'b1;
`endif
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: randomized and directed frames checked against a frame-level model.
module tb_uart_cmd_parser;
  localparam int MAX_LEN = 16;
  localparam int TMO = 40;
  localparam int PW = MAX_LEN*8;
  logic i_Clock = 1'b0;
  logic i_Rst_L = 1'b0;
  logic i_RX_DV = 1'b0;
  logic [7:0] i_RX_Byte = '0;
  logic o_Cmd_DV, o_Err_DV, o_Busy;
  logic [7:0] o_Cmd, o_Len;
  logic [PW-1:0] o_Payload;
  logic [1:0] o_Err_Code;
  int checks = 0;
  int failures = 0;
  byte unsigned fr[$];
  int idle = 0;
  logic e_cmd_dv = 1'b0, e_err_dv = 1'b0;
  logic [7:0] e_cmd = '0, e_len = '0;
  logic [PW-1:0] e_pay = '0;
  logic [1:0] e_code = '0;
  uart_cmd_parser #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TMO)) dut (
    .i_Clock(i_Clock), .i_Rst_L(i_Rst_L), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
    .o_Cmd_DV(o_Cmd_DV), .o_Cmd(o_Cmd), .o_Len(o_Len), .o_Payload(o_Payload),
    .o_Err_DV(o_Err_DV), .o_Err_Code(o_Err_Code), .o_Busy(o_Busy)
  );
  always #5 i_Clock = ~i_Clock;
  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    check("cmd_dv", PW'(o_Cmd_DV), PW'(e_cmd_dv));
    check("err_dv", PW'(o_Err_DV), PW'(e_err_dv));
    check("busy", PW'(o_Busy), PW'(fr.size() != 0));
    check("cmd", PW'(o_Cmd), PW'(e_cmd));
    check("len", PW'(o_Len), PW'(e_len));
    check("err_code", PW'(o_Err_Code), PW'(e_code));
    check("payload", o_Payload, e_pay);
  endtask
  // Frame-level model: fr holds the bytes of the frame in progress, starting with SYNC.
  task automatic model(input logic dv, input logic [7:0] b);
    logic [7:0] sum;
    e_cmd_dv = 1'b0;
    e_err_dv = 1'b0;
    if (!dv) begin
      if (fr.size() != 0) idle++;
`ifdef UART_CMD_TIMEOUT_EN
      if (fr.size() != 0 && idle >= TMO) begin
        e_err_dv = 1'b1;
        e_code = 2'b11;
        fr.delete();
      end
`endif
      return;
    end
    idle = 0;
    if (fr.size() == 0 && b != 8'hA5) return;
    fr.push_back(b);
    if (fr.size() == 3 && fr[2] > MAX_LEN) begin
      e_err_dv = 1'b1;
      e_code = 2'b10;
      fr.delete();
    end else if (fr.size() >= 4 && fr.size() == int'(fr[2]) + 4) begin
      sum = '0;
      for (int k = 1; k < fr.size() - 1; k++) sum ^= fr[k];
      if (sum == fr[fr.size()-1]) begin
        e_cmd_dv = 1'b1;
        e_cmd = fr[1];
        e_len = fr[2];
        e_pay = '0;
        for (int k = 0; k < int'(fr[2]); k++) e_pay[8*k +: 8] = fr[3+k];
      end else begin
        e_err_dv = 1'b1;
        e_code = 2'b01;
      end
      fr.delete();
    end
  endtask
  task automatic step(input logic dv, input logic [7:0] b);
    i_RX_DV = dv;
    i_RX_Byte = dv ? b : 8'($urandom);
    model(dv, b);
    @(posedge i_Clock);
    @(negedge i_Clock);
    check_all();
  endtask
  task automatic send(input int n, input logic [63:0] v);
    for (int i = n - 1; i >= 0; i--) step(1'b1, v[8*i +: 8]);
  endtask
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask
  // Asserts reset between clock edges to exercise the asynchronous path.
  task automatic do_reset();
    #2 i_Rst_L = 1'b0;
    i_RX_DV = 1'b0;
    #1;
    fr.delete();
    idle = 0;
    e_cmd_dv = 1'b0;
    e_err_dv = 1'b0;
    e_cmd = '0;
    e_len = '0;
    e_pay = '0;
    e_code = '0;
    check_all();
    @(negedge i_Clock);
    check_all();
    i_Rst_L = 1'b1;
  endtask
  initial begin
    logic [7:0] len, cs, b;
    @(negedge i_Clock);
    do_reset();
    send(6, 64'hA5_01_02_11_22_30);
    gap(2);
    send(6, 64'hA5_01_02_11_22_31);
    gap(1);
    send(7, 64'hFF_5A_A5_07_00_07);
    send(1, 64'h00);
    send(3, 64'hA5_03_11);
    send(4, 64'hA5_07_00_07);
    send(3, 64'hA5_03_10);
    for (int k = 0; k < 16; k++) step(1'b1, 8'(k * 17));
    step(1'b1, 8'h03 ^ 8'h10 ^ 8'h00);
    send(2, 64'hA5_01);
    gap(TMO + 3);
    send(2, 64'h00_01);
    send(4, 64'hA5_07_00_07);
    send(4, 64'hA5_01_02_11);
    do_reset();
    send(6, 64'hA5_01_02_11_22_30);
    for (int f = 0; f < 300; f++) begin
      if ($urandom_range(0, 3) == 0) step(1'b1, 8'($urandom));
      if ($urandom_range(0, 39) == 0) do_reset();
      len = 8'($urandom_range(0, 20));
      b = 8'($urandom);
      step(1'b1, 8'hA5);
      gap($urandom_range(0, 3));
      step(1'b1, b);
      cs = b ^ len;
      step(1'b1, len);
      for (int k = 0; k < int'(len); k++) begin
        b = 8'($urandom);
        cs ^= b;
        gap($urandom_range(0, 2));
        step(1'b1, b);
        if ($urandom_range(0, 59) == 0) gap(TMO + $urandom_range(0, 2));
      end
      step(1'b1, ($urandom_range(0, 3) == 0) ? cs ^ 8'($urandom_range(1, 255)) : cs);
      gap($urandom_range(0, 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver; consumes its one-cycle byte strobe and byte bus.
- Assembles framed host commands: SYNC, CMD, LEN, LEN payload bytes, CHK.
- Validates each frame and presents command, length and payload to the test-control logic as a one-cycle strobe, or reports an error strobe with a code.

Parameters:
- MAX_LEN, 16, maximum payload bytes per frame (1..255).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CLKS, 10*`CLKS_PER_BIT*4, idle clocks allowed between bytes inside a frame before abort.

Ports:
- i_Clock  in  1  system clock.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_RX_DV  in  1  byte-valid strobe from UART receiver, one cycle per byte.
- i_RX_Byte  in  8  received byte, valid only when i_RX_DV=1.
- o_Cmd_DV  out  1  one-cycle pulse: valid frame accepted.
- o_Cmd  out  8  command byte of last valid frame.
- o_Len  out  8  payload length of last valid frame.
- o_Payload  out  MAX_LEN*8  payload of last valid frame; byte k at bits [8k+7:8k]; bytes at index >= o_Len are zero.
- o_Err_DV  out  1  one-cycle pulse: frame rejected.
- o_Err_Code  out  2  01 checksum mismatch, 10 length > MAX_LEN, 11 inter-byte timeout; held until next error.
- o_Busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: one clock, i_Clock. Reset is asynchronous, active-low (i_Rst_L). While i_Rst_L=0 all outputs are 0, state is IDLE, working buffer, checksum accumulator and counters are 0. Reset mid-frame discards the frame with no strobe.
- Bytes are consumed only in cycles with i_RX_DV=1. No backpressure; every strobed byte is processed.
- States: IDLE, CMD, LEN, PAYLOAD, CHK.
  - IDLE: a byte equal to SYNC_BYTE moves to CMD; any other byte is ignored silently. On entering CMD, clear the accumulator, index and working buffer.
  - CMD: store the byte, accumulator = byte, go to LEN.
  - LEN: accumulator ^= byte.
    - byte > MAX_LEN: next cycle o_Err_DV=1, o_Err_Code=10, go to IDLE.
    - byte == 0: go to CHK.
    - otherwise: go to PAYLOAD, index=0.
  - PAYLOAD: write byte to working buffer[index], accumulator ^= byte, index++. When index reaches LEN, go to CHK.
  - CHK: if byte == accumulator, copy the working registers to o_Cmd, o_Len and o_Payload and pulse o_Cmd_DV. Otherwise pulse o_Err_DV with code 01. Return to IDLE in both cases.
- Latency: o_Cmd_DV or o_Err_DV is high exactly in the cycle after the i_RX_DV of the deciding byte, for one cycle. o_Cmd_DV and o_Err_DV are never high together.
- o_Cmd, o_Len and o_Payload change only on an accepted frame; a rejected frame leaves them untouched.
- A SYNC_BYTE value received inside a frame is treated as data. There is no resynchronisation mid-frame.
- Index and accumulator widths: index is 8 bits; comparisons are unsigned.

Optional Feature:
- Macro: UART_CMD_TIMEOUT_EN.
- Defined: a counter resets to 0 on every i_RX_DV and increments each cycle while state != IDLE. On reaching TIMEOUT_CLKS-1 without a byte, the frame is aborted: next cycle o_Err_DV=1, o_Err_Code=11, state IDLE. If i_RX_DV and expiry coincide, the byte wins and the counter resets.
- Not defined: no counter is present; a partial frame waits indefinitely; code 11 is never produced.

Test Plan:
- Bytes A5 01 02 11 22 30 -> one o_Cmd_DV pulse; o_Cmd=01, o_Len=02, o_Payload[15:0]=16'h2211, upper bytes 0; o_Busy low afterwards.
- Bytes A5 01 02 11 22 31 -> o_Err_DV pulse, o_Err_Code=01; o_Cmd, o_Len and o_Payload keep their previous values.
- Bytes 00 FF 5A A5 07 00 07 -> leading bytes ignored; o_Cmd_DV with o_Cmd=07, o_Len=00, o_Payload all zero.
- Bytes A5 03 11 (MAX_LEN=16) -> o_Err_DV with code 10 one cycle after the third strobe; a following A5 07 00 07 is accepted.
- With UART_CMD_TIMEOUT_EN: bytes A5 01, then silence for TIMEOUT_CLKS cycles -> o_Err_DV with code 11; a following valid frame is accepted. Without the macro: no strobe, o_Busy stays high.
- Assert i_Rst_L=0 after A5 01 02 11, release, then send A5 01 02 11 22 30 -> no strobe during the aborted frame; the new frame is accepted normally.
